alu_pc_datapath: RTL and testbench



---
 rtl/alu_pc_datapath_pkg.sv | 24 ++
 rtl/alu_pc_datapath_if.sv | 36 +++
 rtl/alu_pc_datapath_alu8.sv | 58 +++++
 rtl/alu_pc_datapath.sv | 44 ++++
 tb/tb_alu_pc_datapath.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_pc_datapath_pkg.sv
// Shared definitions for the ALU/PC datapath: opcode encoding used by
// this block and by the control unit.
package alu_pc_datapath_pkg;
  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADC = 4'h0,
    OP_SBC = 4'h1,
    OP_AND = 4'h2,
    OP_ORA = 4'h3,
    OP_EOR = 4'h4,
    OP_ASL = 4'h5,
    OP_LSR = 4'h6,
    OP_ROL = 4'h7,
    OP_ROR = 4'h8,
    OP_INC = 4'h9,
    OP_DEC = 4'hA,
    OP_CMP = 4'hB,
    OP_BIT = 4'hC,
    OP_PSA = 4'hD,
    OP_PSB = 4'hE,
    OP_ADD = 4'hF
  } alu_op_e;
endpackage

// File: rtl/alu_pc_datapath_if.sv
// Bus bundle between control/operand muxes (master) and the ALU/PC
// datapath (slave).
interface alu_pc_datapath_if;
  import alu_pc_datapath_pkg::*;

  logic [7:0]      a;
  logic [7:0]      b;
  logic            carryIn;
  logic            overflowIn;
  logic [OP_W-1:0] operation;
  logic [7:0]      f;
  logic            negative;
  logic            overflow;
  logic            zero;
  logic            carry;
  logic            load_pc_l;
  logic            load_pc_h;
  logic            L_inc;
  logic            H_inc;
  logic [7:0]      PCL_in;
  logic [7:0]      PCH_in;
  logic [7:0]      PCL_out;
  logic [7:0]      PCH_out;

  modport master (
    output a, b, carryIn, overflowIn, operation,
    output load_pc_l, load_pc_h, L_inc, H_inc, PCL_in, PCH_in,
    input  f, negative, overflow, zero, carry, PCL_out, PCH_out
  );

  modport slave (
    input  a, b, carryIn, overflowIn, operation,
    input  load_pc_l, load_pc_h, L_inc, H_inc, PCL_in, PCH_in,
    output f, negative, overflow, zero, carry, PCL_out, PCH_out
  );
endinterface

// File: rtl/alu_pc_datapath_alu8.sv
// Combinational 8-bit ALU, binary arithmetic only. One shared adder
// serves ADC/SBC/CMP/ADD; subtraction is a + ~b + carry.
module alu8
  import alu_pc_datapath_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic       overflow_in,
  input  alu_op_e    op,
  output logic [7:0] f,
  output logic       negative,
  output logic       overflow,
  output logic       zero,
  output logic       carry
);
  logic [7:0] add_b;
  logic       add_c;
  logic [8:0] sum;
  logic       add_v;

  always_comb begin
    add_b = ((op == OP_SBC) || (op == OP_CMP)) ? ~b : b;
    case (op)
      OP_CMP:  add_c = 1'b1;
      OP_ADD:  add_c = 1'b0;
      default: add_c = carry_in;
    endcase
    sum   = {1'b0, a} + {1'b0, add_b} + {8'd0, add_c};
    // signed overflow: like-signed operands producing an opposite-signed sum
    add_v = (a[7] == add_b[7]) && (sum[7] != a[7]);
  end

  always_comb begin
    f        = 8'h00;
    carry    = carry_in;
    overflow = overflow_in;
    case (op)
      OP_ADC, OP_SBC: begin f = sum[7:0]; carry = sum[8]; overflow = add_v; end
      OP_AND: f = a & b;
      OP_ORA: f = a | b;
      OP_EOR: f = a ^ b;
      OP_ASL: begin f = {a[6:0], 1'b0};     carry = a[7]; end
      OP_LSR: begin f = {1'b0, a[7:1]};     carry = a[0]; end
      OP_ROL: begin f = {a[6:0], carry_in}; carry = a[7]; end
      OP_ROR: begin f = {carry_in, a[7:1]}; carry = a[0]; end
      OP_INC: f = a + 8'd1;
      OP_DEC: f = a - 8'd1;
      OP_CMP, OP_ADD: begin f = sum[7:0]; carry = sum[8]; end
      OP_BIT: begin f = a & b; overflow = b[6]; end
      OP_PSA: f = a;
      OP_PSB: f = b;
      default: f = 8'h00;
    endcase
    negative = (op == OP_BIT) ? b[7] : f[7];
    zero     = (f == 8'h00);
  end
endmodule

// File: rtl/alu_pc_datapath.sv
// ALU plus 16-bit program counter held as independently loadable and
// incrementable low/high byte registers.
module alu_pc_datapath
  import alu_pc_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_pc_datapath_if.slave  bus
);
  logic [7:0] pcl;
  logic [7:0] pch;
  logic       pch_inc;

  alu8 u_alu (
    .a           (bus.a),
    .b           (bus.b),
    .carry_in    (bus.carryIn),
    .overflow_in (bus.overflowIn),
    .op          (alu_op_e'(bus.operation)),
    .f           (bus.f),
    .negative    (bus.negative),
    .overflow    (bus.overflow),
    .zero        (bus.zero),
    .carry       (bus.carry)
  );

  // a PCL load suppresses the ripple carry; H_inc and ripple together still add one
  assign pch_inc = bus.H_inc || (bus.L_inc && !bus.load_pc_l && (pcl == 8'hFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcl <= 8'h00;
      pch <= 8'h00;
    end else begin
      if (bus.load_pc_l)  pcl <= bus.PCL_in;
      else if (bus.L_inc) pcl <= pcl + 8'd1;
      if (bus.load_pc_h)  pch <= bus.PCH_in;
      else if (pch_inc)   pch <= pch + 8'd1;
    end
  end

  assign bus.PCL_out = pcl;
  assign bus.PCH_out = pch;
endmodule

// File: tb/tb_alu_pc_datapath.sv
// Randomized self-checking bench: directed corner vectors, then random
// ALU/PC traffic against an arithmetic reference model.
module tb_alu_pc_datapath;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int pc_ref = 0;

  alu_pc_datapath_if bus();

  alu_pc_datapath dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference ALU from integer arithmetic
  task automatic alu_ref(input int op, input int a, input int b, input int ci, input int vi,
                         output int f, output int n, output int v, output int z, output int c);
    int sa, sb, s, sr;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    c = ci; v = vi; f = 0;
    case (op)
      0:  begin s = a + b + ci; f = s & 255; c = int'(s > 255);
                sr = sa + sb + ci; v = int'(sr > 127 || sr < -128); end
      1:  begin s = a - b - (1 - ci); f = s & 255; c = int'(s >= 0);
                sr = sa - sb - (1 - ci); v = int'(sr > 127 || sr < -128); end
      2:  f = a & b;
      3:  f = a | b;
      4:  f = a ^ b;
      5:  begin f = (a * 2) & 255; c = int'(a >= 128); end
      6:  begin f = a / 2; c = a % 2; end
      7:  begin f = (a * 2 + ci) & 255; c = int'(a >= 128); end
      8:  begin f = a / 2 + ci * 128; c = a % 2; end
      9:  f = (a + 1) & 255;
      10: f = (a + 255) & 255;
      11: begin f = (a - b) & 255; c = int'(a >= b); end
      12: begin f = a & b; v = int'(b >= 64 && b < 128 || b >= 192); end
      13: f = a;
      14: f = b;
      default: begin s = a + b; f = s & 255; c = int'(s > 255); end
    endcase
    n = (op == 12) ? int'(b >= 128) : int'(f >= 128);
    z = int'(f == 0);
  endtask

  // 16-bit PC reference: increment as a whole address, then byte loads override
  function automatic int pc_next(input int pc, input logic ll, input logic lh, input logic li,
                                 input logic hi, input int pl, input int ph);
    int nxt, hb, lb;
    nxt = pc;
    if (li) nxt = (pc + 1) % 65536;
    if (hi && (nxt / 256) == (pc / 256)) nxt = (nxt + 256) % 65536;
    lb = nxt % 256;
    hb = nxt / 256;
    if (ll) begin
      lb = pl;
      hb = hi ? ((pc / 256) + 1) % 256 : pc / 256;
    end
    if (lh) hb = ph;
    return hb * 256 + lb;
  endfunction

  task automatic set_alu(input int op, input int a, input int b, input int ci, input int vi);
    bus.operation = op[3:0];
    bus.a = a[7:0];
    bus.b = b[7:0];
    bus.carryIn = ci[0];
    bus.overflowIn = vi[0];
  endtask

  task automatic check_alu(input string tag);
    int f, n, v, z, c;
    alu_ref(int'(bus.operation), int'(bus.a), int'(bus.b), int'(bus.carryIn),
            int'(bus.overflowIn), f, n, v, z, c);
    chk({tag, ".f"}, 32'(bus.f), 32'(f));
    chk({tag, ".nvzc"}, 32'({bus.negative, bus.overflow, bus.zero, bus.carry}),
        32'(n * 8 + v * 4 + z * 2 + c));
  endtask

  task automatic pc_step(input string tag, input logic ll, input logic lh, input logic li,
                         input logic hi, input int pl, input int ph);
    bus.load_pc_l = ll; bus.load_pc_h = lh; bus.L_inc = li; bus.H_inc = hi;
    bus.PCL_in = pl[7:0]; bus.PCH_in = ph[7:0];
    pc_ref = pc_next(pc_ref, ll, lh, li, hi, pl, ph);
    @(posedge clk); #1;
    chk(tag, 32'({bus.PCH_out, bus.PCL_out}), 32'(pc_ref));
    bus.load_pc_l = 0; bus.load_pc_h = 0; bus.L_inc = 0; bus.H_inc = 0;
  endtask

  initial begin
    bus.load_pc_l = 0; bus.load_pc_h = 0; bus.L_inc = 0; bus.H_inc = 0;
    bus.PCL_in = 0; bus.PCH_in = 0;
    set_alu(0, 0, 0, 0, 0);
    #2;
    chk("reset_pc", 32'({bus.PCH_out, bus.PCL_out}), 32'h0000);
    @(negedge clk); rst_n = 1'b1;

    // directed ALU vectors with literal expectations
    set_alu(0, 'h50, 'h50, 0, 0); #1;
    chk("adc.f", 32'(bus.f), 32'hA0);
    chk("adc.nvzc", 32'({bus.negative, bus.overflow, bus.zero, bus.carry}), 32'b1100);
    set_alu(1, 'h00, 'h01, 1, 0); #1;
    chk("sbc.f", 32'(bus.f), 32'hFF);
    chk("sbc.nc", 32'({bus.negative, bus.carry}), 32'b10);
    set_alu(11, 'h10, 'h10, 0, 0); #1;
    chk("cmp_eq", 32'({bus.f, bus.zero, bus.carry}), 32'({8'h00, 2'b11}));
    set_alu(11, 'h0F, 'h10, 1, 0); #1;
    chk("cmp_lt", 32'({bus.negative, bus.carry}), 32'b10);
    set_alu(8, 'h01, 'h00, 1, 0); #1;
    chk("ror", 32'({bus.f, bus.carry}), 32'({8'h80, 1'b1}));
    set_alu(12, 'h01, 'hC0, 0, 0); #1;
    chk("bit", 32'({bus.zero, bus.negative, bus.overflow}), 32'b111);

    // directed PC sequence
    @(posedge clk); #1;
    pc_step("pc_load", 1, 1, 0, 0, 'h34, 'h12);
    chk("pc_1234", 32'({bus.PCH_out, bus.PCL_out}), 32'h1234);
    pc_step("pc_inc", 0, 0, 1, 0, 0, 0);
    chk("pc_1235", 32'({bus.PCH_out, bus.PCL_out}), 32'h1235);
    pc_step("pc_ld12ff", 1, 0, 0, 0, 'hFF, 0);
    pc_step("pc_carry", 0, 0, 1, 0, 0, 0);
    chk("pc_1300", 32'({bus.PCH_out, bus.PCL_out}), 32'h1300);
    pc_step("pc_ldffff", 1, 1, 0, 0, 'hFF, 'hFF);
    pc_step("pc_wrap", 0, 0, 1, 0, 0, 0);
    chk("pc_0000", 32'({bus.PCH_out, bus.PCL_out}), 32'h0000);
    pc_step("pc_ld12ff_b", 1, 1, 0, 0, 'hFF, 'h12);
    pc_step("pc_both_inc", 0, 0, 1, 1, 0, 0);
    chk("pc_both_1300", 32'({bus.PCH_out, bus.PCL_out}), 32'h1300);
    pc_step("pc_ldl_wins", 1, 0, 1, 0, 'hFF, 0);
    pc_step("pc_ldl_nocarry", 1, 0, 1, 0, 'h20, 0);
    chk("pc_1320", 32'({bus.PCH_out, bus.PCL_out}), 32'h1320);
    pc_step("pc_hinc", 0, 0, 0, 1, 0, 0);
    chk("pc_1420", 32'({bus.PCH_out, bus.PCL_out}), 32'h1420);

    // async reset mid-increment, between edges
    bus.L_inc = 1;
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async_rst", 32'({bus.PCH_out, bus.PCL_out}), 32'h0000);
    @(posedge clk); #1;
    chk("rst_held", 32'({bus.PCH_out, bus.PCL_out}), 32'h0000);
    @(negedge clk); rst_n = 1'b1; bus.L_inc = 0;
    pc_ref = 0;
    #2;
    chk("rst_release", 32'({bus.PCH_out, bus.PCL_out}), 32'h0000);
    @(posedge clk); #1;

    // random traffic: ALU checked combinationally, PC after each edge
    for (int i = 0; i < 400; i++) begin
      int ll, lh, li, hi;
      set_alu(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)));
      #1;
      check_alu("alu_rnd");
      ll = int'($urandom_range(0, 7) == 0);
      lh = int'($urandom_range(0, 7) == 0);
      li = int'($urandom_range(0, 1));
      hi = int'($urandom_range(0, 5) == 0);
      // bias toward the carry boundary
      if ($urandom_range(0, 9) == 0) begin ll = 1; end
      pc_step("pc_rnd", ll[0], lh[0], li[0], hi[0],
              ($urandom_range(0, 3) == 0) ? 'hFF : int'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0) ? 'hFF : int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
